io_input_conditioner: RTL and testbench

//  Conditions the raw external push-button and supplies the CPU's two memory-mapped input words.

---
 rtl/io_input_conditioner.sv | 135 +++++++++++++
 tb/tb_io_input_conditioner.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/io_input_conditioner.sv
// -----------------------------------------------------------------------------
// io_input_conditioner
//   Conditions a raw external push-button and presents the two memory-mapped
//   input words read by the CPU (ioin1 / ioin2).
//   Button path: 2-flop synchroniser -> debouncer -> rising-edge detect ->
//   sticky trigger flag + 8-bit press counter. A free-running 7-bit LFSR is
//   captured on every accepted press to give software a random delay seed.
//
// Ports
//   clk      in   1   system clock, rising edge
//   rst      in   1   asynchronous reset, active-high
//   btn_i    in   1   raw asynchronous push-button level
//   ack_i    in   1   clears the sticky trigger flag (one-cycle pulse)
//   trig_o   out  1   one-cycle pulse after each accepted press
//   ioin1_o  out  32  {23'b0, press_cnt[7:0], trig_flag}
//   ioin2_o  out  32  {25'b0, rand_q[6:0]}
// -----------------------------------------------------------------------------
module io_input_conditioner #(
  parameter int         DEBOUNCE_CYCLES = 4,
  parameter int         CNT_W           = 16,
  parameter logic [6:0] LFSR_SEED       = 7'h01
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_i,
  input  logic        ack_i,
  output logic        trig_o,
  output logic [31:0] ioin1_o,
  output logic [31:0] ioin2_o
);

  // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
  localparam logic [6:0]       SEED_EFF = (LFSR_SEED == 7'h00) ? 7'h01 : LFSR_SEED;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // x^7 + x^6 + 1 Fibonacci step, maximal period 127.
  function automatic logic [6:0] lfsr_next(input logic [6:0] cur);
    return {cur[5:0], cur[6] ^ cur[5]};
  endfunction

  logic             s1;
  logic             btn_sync;
  logic             btn_stable;
  logic [CNT_W-1:0] cnt;
  logic             trig_flag;
  logic [7:0]       press_cnt;
  logic [6:0]       rand_q;
  logic [6:0]       lfsr;

  logic             differ;
  logic             cnt_done;
  logic             press;

  // Debounce decode: a press is the edge where btn_stable is about to go 0->1.
  always_comb begin
    differ   = 1'b0;
    cnt_done = 1'b0;
    press    = 1'b0;
    differ   = btn_sync ^ btn_stable;
    if (differ && (cnt == CNT_LAST)) begin
      cnt_done = 1'b1;
    end else begin
      cnt_done = 1'b0;
    end
    press = cnt_done & btn_sync;
  end

  // Two-flop synchroniser for the asynchronous button level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1       <= 1'b0;
      btn_sync <= 1'b0;
    end else begin
      s1       <= btn_i;
      btn_sync <= s1;
    end
  end

  // Debouncer: accept a new level after DEBOUNCE_CYCLES consecutive differing samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_stable <= 1'b0;
      cnt        <= '0;
    end else if (!differ) begin
      cnt <= '0;
    end else if (cnt_done) begin
      btn_stable <= btn_sync;
      cnt        <= '0;
    end else begin
      cnt <= cnt + CNT_ONE;
    end
  end

  // Sticky trigger flag; a press on the same edge as ack_i keeps it set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trig_flag <= 1'b0;
    end else if (press) begin
      trig_flag <= 1'b1;
    end else if (ack_i) begin
      trig_flag <= 1'b0;
    end else begin
      trig_flag <= trig_flag;
    end
  end

  // Press pulse, wrapping press counter and LFSR snapshot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trig_o    <= 1'b0;
      press_cnt <= 8'h00;
      rand_q    <= 7'h00;
    end else if (press) begin
      trig_o    <= 1'b1;
      press_cnt <= press_cnt + 8'd1;
      rand_q    <= lfsr;
    end else begin
      trig_o    <= 1'b0;
    end
  end

  // Free-running LFSR, advances every cycle out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr <= SEED_EFF;
    end else begin
      lfsr <= lfsr_next(lfsr);
    end
  end

  assign ioin1_o = {23'd0, press_cnt, trig_flag};
  assign ioin2_o = {25'd0, rand_q};

endmodule

// File: tb/tb_io_input_conditioner.sv
// -----------------------------------------------------------------------------
// tb_io_input_conditioner
//   Directed bench for io_input_conditioner (DEBOUNCE_CYCLES=4, LFSR seed 1).
//   Inputs are driven 1 time unit after a rising edge; outputs are sampled at
//   the same point, so "after edge N" means the state just after edge N.
// -----------------------------------------------------------------------------
module tb_io_input_conditioner;

  logic        clk   = 1'b0;
  logic        rst   = 1'b1;
  logic        btn_i = 1'b0;
  logic        ack_i = 1'b0;
  logic        trig_o;
  logic [31:0] ioin1_o;
  logic [31:0] ioin2_o;

  int checks   = 0;
  int failures = 0;

  io_input_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W(16),
    .LFSR_SEED(7'h01)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_i(btn_i),
    .ack_i(ack_i),
    .trig_o(trig_o),
    .ioin1_o(ioin1_o),
    .ioin2_o(ioin2_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reset is released just after an edge, so the next edge is edge 1.
  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    step(2);
    rst = 1'b0;
  endtask

  initial begin
    // 1: reset and idle
    step(2);
    check("rst_ioin1", ioin1_o, 32'h0);
    check("rst_ioin2", ioin2_o, 32'h0);
    check("rst_trig", 32'(trig_o), 32'h0);
    rst = 1'b0;
    step(7);
    check("idle_ioin1", ioin1_o, 32'h0);
    check("idle_ioin2", ioin2_o, 32'h0);
    check("idle_trig", 32'(trig_o), 32'h0);

    // LFSR after 7 edges is 0x03: press accepted at edge 8 snapshots it
    do_reset();
    step(2);
    btn_i = 1'b1;              // before edge 3 -> accepted at edge 8
    step(5);
    check("lfsr7_pre_trig", 32'(trig_o), 32'h0);
    step(1);
    check("lfsr7_trig", 32'(trig_o), 32'h1);
    check("lfsr7_ioin2", ioin2_o, 32'h03);
    btn_i = 1'b0;
    step(10);

    // 2: press with btn high before edge 1 -> accepted at edge 6
    do_reset();
    btn_i = 1'b1;
    step(5);
    check("p1_edge5_trig", 32'(trig_o), 32'h0);
    check("p1_edge5_ioin1", ioin1_o, 32'h0);
    step(1);
    check("p1_edge6_trig", 32'(trig_o), 32'h1);
    check("p1_edge6_ioin1", ioin1_o, 32'h3);
    check("p1_edge6_ioin2", ioin2_o, 32'h20);
    step(1);
    check("p1_edge7_trig", 32'(trig_o), 32'h0);
    step(3);
    check("p1_hold_trig", 32'(trig_o), 32'h0);
    btn_i = 1'b0;              // release: debounced, no other effect
    step(8);
    check("p1_release_ioin1", ioin1_o, 32'h3);
    check("p1_release_trig", 32'(trig_o), 32'h0);

    // 3: 3-cycle glitch is rejected
    btn_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1);
      check("glitch_hi_trig", 32'(trig_o), 32'h0);
    end
    btn_i = 1'b0;
    step(2);
    check("glitch_cnt_peak", 32'(dut.cnt), 32'h3);
    step(1);
    check("glitch_cnt_clear", 32'(dut.cnt), 32'h0);
    for (int i = 0; i < 4; i++) begin
      step(1);
      check("glitch_lo_trig", 32'(trig_o), 32'h0);
    end
    check("glitch_ioin1", ioin1_o, 32'h3);

    // 4: ack clears flag; ack on a clear flag does nothing; press beats ack
    ack_i = 1'b1;
    step(1);
    ack_i = 1'b0;
    check("ack_ioin1", ioin1_o, 32'h2);
    ack_i = 1'b1;
    step(1);
    ack_i = 1'b0;
    check("ack_idle_ioin1", ioin1_o, 32'h2);
    btn_i = 1'b1;
    step(5);
    check("p2_pre_ioin1", ioin1_o, 32'h2);
    ack_i = 1'b1;              // coincides with the accepting edge
    step(1);
    ack_i = 1'b0;
    check("p2_ack_ioin1", ioin1_o, 32'h5);
    check("p2_ack_trig", 32'(trig_o), 32'h1);
    btn_i = 1'b0;
    step(8);

    // 5: 256 presses wrap the counter to 0 with the flag still set
    do_reset();
    for (int i = 0; i < 256; i++) begin
      btn_i = 1'b1;
      step(8);
      btn_i = 1'b0;
      step(8);
      if (i == 254) begin
        check("wrap_255_ioin1", ioin1_o, 32'h1FF);
      end
    end
    check("wrap_ioin1", ioin1_o, 32'h1);
    check("wrap_trig", 32'(trig_o), 32'h0);

    // 6: reset mid-debounce, then press accepted 6 edges after release
    btn_i = 1'b1;
    step(4);
    check("mid_cnt", 32'(dut.cnt), 32'h2);
    rst = 1'b1;
    #1;
    check("async_ioin1", ioin1_o, 32'h0);
    check("async_ioin2", ioin2_o, 32'h0);
    check("async_trig", 32'(trig_o), 32'h0);
    check("async_cnt", 32'(dut.cnt), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(5);
    check("post_rst_edge5_trig", 32'(trig_o), 32'h0);
    check("post_rst_edge5_ioin1", ioin1_o, 32'h0);
    step(1);
    check("post_rst_edge6_trig", 32'(trig_o), 32'h1);
    check("post_rst_edge6_ioin1", ioin1_o, 32'h3);
    check("post_rst_edge6_ioin2", ioin2_o, 32'h20);
    step(1);
    check("post_rst_edge7_trig", 32'(trig_o), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
